of_operand_fetch: RTL and testbench

//  Operand-fetch stage of the 5-stage SimpleRisc pipeline; sits between the IF/OF latch and the OF/EX latch.

---
 rtl/simplerisc_pkg.sv | 51 +++++
 rtl/of_regfile.sv | 45 ++++
 rtl/of_operand_fetch.sv | 103 ++++++++++
 tb/tb_of_operand_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: widths, opcodes, instruction field positions, NOP encoding.
package simplerisc_pkg;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned OPC_W  = 5;

  // Instruction field positions
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned OPC_LSB  = 27;
  localparam int unsigned I_BIT    = 26;
  localparam int unsigned RD_MSB   = 25;
  localparam int unsigned RD_LSB   = 22;
  localparam int unsigned RS1_MSB  = 21;
  localparam int unsigned RS1_LSB  = 18;
  localparam int unsigned RS2_MSB  = 17;
  localparam int unsigned RS2_LSB  = 14;
  localparam int unsigned MOD_MSB  = 17;
  localparam int unsigned MOD_LSB  = 16;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned OFF_MSB  = 26;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd2;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'd3;
  localparam logic [OPC_W-1:0] OP_MOD  = 5'd4;
  localparam logic [OPC_W-1:0] OP_CMP  = 5'd5;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd6;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd7;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd8;
  localparam logic [OPC_W-1:0] OP_MOV  = 5'd9;
  localparam logic [OPC_W-1:0] OP_LSL  = 5'd10;
  localparam logic [OPC_W-1:0] OP_LSR  = 5'd11;
  localparam logic [OPC_W-1:0] OP_ASR  = 5'd12;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd13;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd14;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd15;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'd16;
  localparam logic [OPC_W-1:0] OP_BGT  = 5'd17;
  localparam logic [OPC_W-1:0] OP_B    = 5'd18;
  localparam logic [OPC_W-1:0] OP_CALL = 5'd19;
  localparam logic [OPC_W-1:0] OP_RET  = 5'd20;

  localparam logic [XLEN-1:0]   NOP_INSN = 32'h6800_0000;
  localparam logic [REG_AW-1:0] RA_IDX   = 4'd15;

endpackage

// File: rtl/of_regfile.sv
// 16x32 architectural register file: 2 combinational read ports, 1 write port.
// Ports: clk, reset (sync, active-high, clears all registers);
//        rd_addr1/rd_data1, rd_addr2/rd_data2 read ports;
//        wb_en/wb_rd/wb_data write port (every register, r0 included, is writable).
// Build option: WB_BYPASS_EN makes a read of the register being written return wb_data.
module of_regfile
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [XLEN-1:0]   rd_data1,
  output logic [XLEN-1:0]   rd_data2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: synchronous clear, single write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports
`ifdef WB_BYPASS_EN
  // Write-through: same-cycle writeback is visible to the reader
  always_comb begin
    rd_data1 = (wb_en && (wb_rd == rd_addr1)) ? wb_data : regs[rd_addr1];
    rd_data2 = (wb_en && (wb_rd == rd_addr2)) ? wb_data : regs[rd_addr2];
  end
`else
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
  end
`endif

endmodule

// File: rtl/of_operand_fetch.sv
// SimpleRisc operand-fetch stage: decode, register read, immediate generation,
// operand selection and branch-target computation. Fully combinational outputs.
// Ports: clk, reset (sync, active-high; forces a NOP bubble on the outputs);
//        Input_OF_PC/Input_OF_IR from the IF/OF latch; wb_en/wb_rd/wb_data writeback port;
//        isStore, isReturn, isImmendiate flags; output_OF_PC/output_OF_IR pass-through;
//        branchTarget, Operand_A, Operand_B, Operand_2 to the OF/EX latch.
// Build option: WB_BYPASS_EN (register file write-through, see of_regfile).
module of_operand_fetch
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   Input_OF_PC,
  input  logic [XLEN-1:0]   Input_OF_IR,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              isStore,
  output logic              isReturn,
  output logic              isImmendiate,
  output logic [PC_W-1:0]   output_OF_PC,
  output logic [XLEN-1:0]   output_OF_IR,
  output logic [XLEN-1:0]   branchTarget,
  output logic [XLEN-1:0]   Operand_A,
  output logic [XLEN-1:0]   Operand_B,
  output logic [XLEN-1:0]   Operand_2
);

  logic [OPC_W-1:0]  opcode;
  logic              i_bit;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [1:0]        imm_mod;
  logic [15:0]       imm16;
  logic              is_st, is_ret;
  logic [REG_AW-1:0] rd_addr1, rd_addr2;
  logic [XLEN-1:0]   rd_data1, rd_data2;
  logic [XLEN-1:0]   imm_val;
  logic [XLEN-1:0]   target;

  // Field extraction and opcode-only flag decode
  always_comb begin
    opcode   = Input_OF_IR[OPC_MSB:OPC_LSB];
    i_bit    = Input_OF_IR[I_BIT];
    rd       = Input_OF_IR[RD_MSB:RD_LSB];
    rs1      = Input_OF_IR[RS1_MSB:RS1_LSB];
    rs2      = Input_OF_IR[RS2_MSB:RS2_LSB];
    imm_mod  = Input_OF_IR[MOD_MSB:MOD_LSB];
    imm16    = Input_OF_IR[IMM_MSB:0];
    is_st    = (opcode == OP_ST);
    is_ret   = (opcode == OP_RET);
    // ret reads the return address; st reads its data register on port 2
    rd_addr1 = is_ret ? RA_IDX : rs1;
    rd_addr2 = is_st  ? rd     : rs2;
  end

  of_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  // Immediate generator and branch adder
  always_comb begin
    unique case (imm_mod)
      2'b01:   imm_val = {16'h0000, imm16};
      2'b10:   imm_val = {imm16, 16'h0000};
      default: imm_val = {{16{imm16[15]}}, imm16};
    endcase
    target = XLEN'(Input_OF_PC)
           + {{3{Input_OF_IR[OFF_MSB]}}, Input_OF_IR[OFF_MSB:0], 2'b00};
  end

  // Output mux; reset presents a NOP bubble
  always_comb begin
    isStore      = 1'b0;
    isReturn     = 1'b0;
    isImmendiate = 1'b0;
    output_OF_PC = '0;
    output_OF_IR = NOP_INSN;
    branchTarget = '0;
    Operand_A    = '0;
    Operand_B    = '0;
    Operand_2    = '0;
    if (!reset) begin
      isStore      = is_st;
      isReturn     = is_ret;
      isImmendiate = i_bit;
      output_OF_PC = Input_OF_PC;
      output_OF_IR = Input_OF_IR;
      branchTarget = target;
      Operand_A    = rd_data1;
      Operand_2    = rd_data2;
      Operand_B    = i_bit ? imm_val : rd_data2;
    end
  end

endmodule

// File: tb/tb_of_operand_fetch.sv
// Scoreboard bench for of_operand_fetch: a driver issues directed then random
// instructions and queues expectations from a behavioural model; a monitor
// compares the DUT outputs against the queue each cycle.
module tb_of_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pc;
  logic [31:0] ir;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        is_store, is_return, is_imm;
  logic [9:0]  o_pc;
  logic [31:0] o_ir, b_tgt, op_a, op_b, op_2;

  always #5 clk = ~clk;

  of_operand_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .Input_OF_PC  (pc),
    .Input_OF_IR  (ir),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .isStore      (is_store),
    .isReturn     (is_return),
    .isImmendiate (is_imm),
    .output_OF_PC (o_pc),
    .output_OF_IR (o_ir),
    .branchTarget (b_tgt),
    .Operand_A    (op_a),
    .Operand_B    (op_b),
    .Operand_2    (op_2)
  );

  typedef struct {
    string       tag;
    logic        st, ret, imm;
    logic [9:0]  pc;
    logic [31:0] ir, tgt, a, b, o2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_regs [16];
  int          checks = 0;
  int          errors = 0;
  bit          done   = 1'b0;

  // Register read as the architecture defines it, including optional write-through
  function automatic logic [31:0] model_read(int idx, logic we, logic [3:0] wa, logic [31:0] wd);
`ifdef WB_BYPASS_EN
    if (we && int'(wa) == idx) return wd;
`endif
    return model_regs[idx];
  endfunction

  // Drive one cycle of stimulus and queue the expected response
  task automatic drive(string tag, logic rst, logic [9:0] p, logic [31:0] i,
                       logic we, logic [3:0] wa, logic [31:0] wd);
    exp_t e;
    int   opc, a_idx, b_idx, mode, imm;
    @(posedge clk); #1;
    reset = rst; pc = p; ir = i; wb_en = we; wb_rd = wa; wb_data = wd;
    e.tag = tag;
    if (rst) begin
      e.st = 0; e.ret = 0; e.imm = 0; e.pc = 0; e.ir = 32'h6800_0000;
      e.tgt = 0; e.a = 0; e.b = 0; e.o2 = 0;
      for (int k = 0; k < 16; k++) model_regs[k] = 0;
    end else begin
      opc   = int'(i >> 27);
      e.st  = (opc == 15);
      e.ret = (opc == 20);
      e.imm = i[26];
      e.pc  = p;
      e.ir  = i;
      a_idx = e.ret ? 15 : int'((i >> 18) & 32'hF);
      b_idx = e.st ? int'((i >> 22) & 32'hF) : int'((i >> 14) & 32'hF);
      e.a   = model_read(a_idx, we, wa, wd);
      e.o2  = model_read(b_idx, we, wa, wd);
      mode  = int'((i >> 16) & 32'h3);
      imm   = int'(i & 32'hFFFF);
      if (mode == 1)      e.b = 32'(imm);
      else if (mode == 2) e.b = 32'(imm) * 32'h1_0000;
      else                e.b = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm);
      if (!e.imm) e.b = e.o2;
      // Word offset: 27-bit signed value scaled by 4, wrapped to 32 bits
      begin
        longint off;
        off = longint'(i & 32'h07FF_FFFF);
        if (off >= 64'sd67108864) off = off - 64'sd134217728;
        e.tgt = 32'(longint'(p) + off * 4);
      end
      if (we) model_regs[wa] = wd;
    end
    sb_q.push_back(e);
  endtask

  task automatic chk(string tag, string fld, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.tag, "isStore",  32'(is_store),  32'(e.st));
        chk(e.tag, "isReturn", 32'(is_return), 32'(e.ret));
        chk(e.tag, "isImm",    32'(is_imm),    32'(e.imm));
        chk(e.tag, "pc",       32'(o_pc),      32'(e.pc));
        chk(e.tag, "ir",       o_ir,           e.ir);
        chk(e.tag, "target",   b_tgt,          e.tgt);
        chk(e.tag, "opA",      op_a,           e.a);
        chk(e.tag, "opB",      op_b,           e.b);
        chk(e.tag, "op2",      op_2,           e.o2);
      end
    end
  end

  initial begin
    reset = 1'b1; pc = '0; ir = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    drive("rst0", 1, 10'h3FF, 32'h004C_C000, 1, 4'd1, 32'h1234);
    drive("rst1", 1, 10'h001, 32'h004C_C000, 0, 4'd0, 32'h0);
    drive("add_zero", 0, 10'h004, 32'h004C_C000, 0, 4'd0, 32'h0);
    drive("wb_r2", 0, 10'h008, 32'h6800_0000, 1, 4'd2, 32'd5);
    drive("wb_r3", 0, 10'h00C, 32'h6800_0000, 1, 4'd3, 32'd7);
    drive("add", 0, 10'h010, 32'h004C_C000, 0, 4'd0, 32'h0);
    drive("mov_sext", 0, 10'h014, 32'h4C40_FFFF, 0, 4'd0, 32'h0);
    drive("mov_zext", 0, 10'h018, 32'h4C41_FFFF, 0, 4'd0, 32'h0);
    drive("mov_hi",   0, 10'h01C, 32'h4C42_FFFF, 0, 4'd0, 32'h0);
    drive("mov_m11",  0, 10'h01C, 32'h4C43_8001, 0, 4'd0, 32'h0);
    drive("wb_r5", 0, 10'h020, 32'h6800_0000, 1, 4'd5, 32'hAA);
    drive("wb_r6", 0, 10'h024, 32'h6800_0000, 1, 4'd6, 32'h100);
    drive("st", 0, 10'h028, 32'h7D58_0004, 0, 4'd0, 32'h0);
    drive("wb_r15", 0, 10'h02C, 32'h6800_0000, 1, 4'd15, 32'h3C);
    drive("ret", 0, 10'h030, 32'hA000_0000, 0, 4'd0, 32'h0);
    drive("branch", 0, 10'h010, 32'h97FF_FFFE, 0, 4'd0, 32'h0);
    drive("br_wrap", 0, 10'h000, 32'h97FF_FFFF, 0, 4'd0, 32'h0);
    drive("bypass", 0, 10'h034, 32'h004C_C000, 1, 4'd2, 32'd9);
    drive("after_wb", 0, 10'h038, 32'h004C_C000, 0, 4'd0, 32'h0);
    drive("wb_r0", 0, 10'h03C, 32'h6800_0000, 1, 4'd0, 32'hDEAD_BEEF);
    drive("rd_r0", 0, 10'h040, 32'h0040_0000, 0, 4'd0, 32'h0);
    drive("undef_op", 0, 10'h044, 32'hF848_8000, 0, 4'd0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ri;
      ri = $urandom();
      // Bias toward st/ret so the port-address overrides see traffic
      case ($urandom_range(0, 7))
        0: ri = {5'd15, ri[26:0]};
        1: ri = {5'd20, ri[26:0]};
        default: ;
      endcase
      drive("rand", ($urandom_range(0, 63) == 0), 10'($urandom()), ri,
            1'($urandom()), 4'($urandom()), $urandom());
    end
    @(posedge clk);
    @(posedge clk);
    done = 1'b1;
  end

  // Finish once the queue drains, with an overall time bound
  initial begin
    fork
      wait (done);
      #100000;
    join_any
    disable fork;
    repeat (2) @(negedge clk);
    checks++;
    if (!done || sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending (done=%0d)", sb_q.size(), done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
